// File: rtl/huffman_param.sv
// Per-frame symbol histogram followed by a Huffman tree build (two-minimum merges).
// Define HUFF_SAT_EN to make counts saturate at 2^CW-1; otherwise they wrap.
module huffman_param #(
    parameter int NSYM = 6,
    parameter int CW   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 gray_valid,
    input  logic [7:0]           gray_data,
    output logic                 in_ready,
    output logic                 cnt_valid,
    output logic [NSYM*CW-1:0]   cnt,
    output logic                 code_valid,
    output logic [NSYM*8-1:0]    hc,
    output logic [NSYM*8-1:0]    m
);

    localparam int IW = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int WW = CW + 3;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NSYM - 1);
    localparam logic [IW-1:0] LAST_MERGE = IW'(NSYM - 2);

    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_SCAN, S_MERGE, S_DONE} state_t;
    state_t state;

    logic [CW-1:0]   count_r [NSYM];
    logic [7:0]      code_r  [NSYM];
    logic [7:0]      mask_r  [NSYM];
    logic [WW-1:0]   node_w  [NSYM];
    logic [NSYM-1:0] node_m  [NSYM];
    logic [NSYM-1:0] node_act;
    logic [IW-1:0]   scan_idx, merge_cnt, min1, min2;
    logic            min1_ok, min2_ok;

    logic            sample_hit;
    logic [IW-1:0]   sample_sym;

    always_comb begin
        sample_hit = gray_valid && (gray_data != 8'd0) && (gray_data <= 8'(NSYM));
        sample_sym = IW'(gray_data - 8'd1);
    end

    function automatic logic [CW-1:0] bump(input logic [CW-1:0] c);
`ifdef HUFF_SAT_EN
        return (&c) ? c : c + CW'(1);
`else
        return c + CW'(1);
`endif
    endfunction

    assign in_ready = (state == S_IDLE) || (state == S_COUNT);

    for (genvar g = 0; g < NSYM; g++) begin : g_pack
        assign cnt[g*CW +: CW] = count_r[g];
        assign hc[g*8 +: 8]    = code_r[g];
        assign m[g*8 +: 8]     = mask_r[g];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt_valid  <= 1'b0;
            code_valid <= 1'b0;
            scan_idx   <= '0;
            merge_cnt  <= '0;
            min1       <= '0;
            min2       <= '0;
            min1_ok    <= 1'b0;
            min2_ok    <= 1'b0;
            node_act   <= '0;
            for (int k = 0; k < NSYM; k++) begin
                count_r[k] <= '0;
                code_r[k]  <= '0;
                mask_r[k]  <= '0;
                node_w[k]  <= '0;
                node_m[k]  <= '0;
            end
        end else begin
            cnt_valid  <= 1'b0;
            code_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gray_valid) begin
                        for (int k = 0; k < NSYM; k++) begin
                            count_r[k] <= (sample_hit && sample_sym == IW'(k)) ? CW'(1) : '0;
                            code_r[k]  <= '0;
                            mask_r[k]  <= '0;
                        end
                        state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (gray_valid) begin
                        if (sample_hit)
                            count_r[sample_sym] <= bump(count_r[sample_sym]);
                    end else begin
                        for (int k = 0; k < NSYM; k++) begin
                            node_w[k] <= WW'(count_r[k]);
                            node_m[k] <= NSYM'(1) << k;
                        end
                        node_act  <= '1;
                        scan_idx  <= '0;
                        merge_cnt <= '0;
                        min1_ok   <= 1'b0;
                        min2_ok   <= 1'b0;
                        cnt_valid <= 1'b1;
                        state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Strict less-than keeps the lower index ahead on equal weights.
                    if (node_act[scan_idx]) begin
                        if (!min1_ok || node_w[scan_idx] < node_w[min1]) begin
                            min2    <= min1;
                            min2_ok <= min1_ok;
                            min1    <= scan_idx;
                            min1_ok <= 1'b1;
                        end else if (!min2_ok || node_w[scan_idx] < node_w[min2]) begin
                            min2    <= scan_idx;
                            min2_ok <= 1'b1;
                        end
                    end
                    if (scan_idx == LAST_IDX)
                        state <= S_MERGE;
                    else
                        scan_idx <= scan_idx + IW'(1);
                end
                S_MERGE: begin
                    // mask+1 is the bit just above the current code length.
                    for (int k = 0; k < NSYM; k++) begin
                        if (node_m[min1][k]) begin
                            code_r[k] <= code_r[k] | (mask_r[k] + 8'd1);
                            mask_r[k] <= {mask_r[k][6:0], 1'b1};
                        end else if (node_m[min2][k]) begin
                            mask_r[k] <= {mask_r[k][6:0], 1'b1};
                        end
                    end
                    node_w[min1]   <= node_w[min1] + node_w[min2];
                    node_m[min1]   <= node_m[min1] | node_m[min2];
                    node_act[min2] <= 1'b0;
                    scan_idx       <= '0;
                    min1_ok        <= 1'b0;
                    min2_ok        <= 1'b0;
                    merge_cnt      <= merge_cnt + IW'(1);
                    if (merge_cnt == LAST_MERGE) begin
                        code_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        state <= S_SCAN;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/huffman_param.md
# huffman_param

Parametrised Huffman code generator for the image-statistics path. It counts the occurrences of `NSYM` gray-level symbols in a frame, then builds a Huffman tree by iterative two-minimum merges, producing a right-aligned code and mask per symbol. It succeeds the fixed 6-symbol encoder. Improvements over that encoder: arbitrary `NSYM`, deterministic tie-breaking, and re-arming for back-to-back frames.

## Interface
- `NSYM`, 6, number of symbols (legal 2..8); gray value v in 1..NSYM maps to symbol v-1.
- `CW`, 8, count width per symbol.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `gray_valid` in 1: sample strobe; frame = contiguous high run.
- `gray_data` in 8: sample; full 8-bit compare, values 0 and >NSYM ignored.
- `in_ready` out 1: high in IDLE/COUNT; samples outside these states are dropped.
- `cnt_valid` out 1: one-cycle pulse, counts final.
- `cnt` out NSYM*CW: symbol k count at [k*CW +: CW].
- `code_valid` out 1: one-cycle pulse, codes final.
- `hc` out NSYM*8: symbol k code at [k*8 +: 8], right-aligned, root bit MSB of used field.
- `m` out NSYM*8: symbol k mask, (1<<len)-1.

## Operation
- States: IDLE, COUNT, SCAN, MERGE, DONE.
- IDLE: `gray_valid`=1 clears all counts, codes, lengths, then applies the current sample; go COUNT.
- COUNT: each valid sample increments its symbol count. The first cycle with `gray_valid`=0 goes to SCAN and sets `cnt_valid`.
- Node table: NSYM entries, each with weight (CW+3 bits), member mask (NSYM bits) and active flag. Init: node k = count k, mask = 1<<k, active.
- All NSYM symbols participate, zero counts included.
- SCAN: NSYM cycles, one node examined per cycle (index 0..NSYM-1). Running min1/min2 are tracked over active nodes.
- Ordering: lower weight first; equal weight → lower index first.
- MERGE: one cycle.
  - Node min1 takes weight min1+min2 and mask OR; node min2 is deactivated.
  - Every member of min1 has bit 1 prepended (code[len]=1, len++); every member of min2 has bit 0 prepended.
  - Then SCAN again, or DONE after NSYM-1 merges.
- DONE: `code_valid`=1 for one cycle, then IDLE.
- `hc`, `m`, `cnt` hold until the first sample of the next frame.
- Weight sums use CW+3 bits and never overflow for NSYM≤8.

## Timing
- Reset: state IDLE; all counts, codes, masks, node regs 0; `cnt_valid`=`code_valid`=0; `in_ready`=1.
- `cnt_valid` is registered; it is high the cycle after the first `gray_valid`=0 in COUNT, which is also the first SCAN cycle.
- `code_valid` rises (NSYM+1)*(NSYM-1) cycles after `cnt_valid` rises (35 for NSYM=6).
- `gray_valid` during SCAN/MERGE/DONE is ignored; no count change.
- `gray_valid`=1 in the IDLE cycle directly after DONE starts a new frame.
- Reset mid-operation: immediate return to reset values; no pulse is emitted for the aborted frame.
- A one-sample frame is legal; it produces cnt_valid and codes as normal.

## Configuration
- `HUFF_SAT_EN` defined: counts saturate at 2^CW-1.
- Undefined: counts wrap modulo 2^CW.
- Tree building is identical either way and uses the stored count.

## Test plan
- Frame 4×1, 3×2, 2×3, 1×4, 1×5, 1×6 (NSYM=6) → `cnt`={4,3,2,1,1,1}; `code_valid` 35 cycles after `cnt_valid`.
  - hc = {0x00,0x02,0x02,0x07,0x06,0x03}.
  - m = {0x03,0x03,0x07,0x07,0x07,0x07}.
- Frame 2× each of 1..6 → hc = {0x03,0x02,0x01,0x00,0x03,0x02}; m = {0x07,0x07,0x07,0x07,0x03,0x03}.
- Frame 300×1, CW=8:
  - `HUFF_SAT_EN` → cnt0=255.
  - Without → cnt0=44.
- Frame containing values 0, 7, 200 interleaved with 5×3 → only cnt2=5; ignored values leave all other counts 0.
- Reset asserted in the 10th SCAN cycle → all outputs 0 and no `code_valid`. A following frame then completes with correct codes.
- Two back-to-back frames (second starts the cycle after DONE) → outputs cleared at the first sample. Second `code_valid` carries only the second frame's codes.
